mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates a single-ported, fixed-latency backing memory between the instruction-fetch port and the memory-stage data port of the 16-bit pipelined processor. It serialises accesses, one outstanding at a time, and returns a one-cycle done pulse per access. Requesters stall on `req & ~done`. It sits between the fetch/memory stages and the unified memory, replacing the separate instruction and data memories.

Parameters:
- LATENCY, 2: cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- i_req  in  1  fetch read request; held until i_done or i_cancel.
- i_addr  in  AW  fetch address.
- i_cancel  in  1  abandon the fetch (branch redirect).
- i_done  out  1  one-cycle fetch completion pulse.
- i_rdata  out  DW  fetched word; valid only with i_done.
- d_req  in  1  data request; held until d_done.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_done  out  1  one-cycle data completion pulse.
- d_rdata  out  DW  load data; valid with d_done; 0 for writes.
- d_err  out  1  unaligned access; pulses together with d_done.
- halt  in  1  processor halted; no new fetch grants.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_wr  out  1  write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid LATENCY cycles after mem_en.

Behaviour:
- All outputs are registered. In reset every output is 0, state = IDLE, counter = 0 and the winner register is cleared.
- Reset applied mid-access abandons the access. No done pulse is produced, and outputs are 0 in the cycle after the reset edge.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE, arbitration at the clock edge:
  - A pending d_req wins (older instruction), regardless of i_req.
  - Otherwise i_req wins, provided halt=0 and i_cancel=0.
  - The winner's address, wr and wdata are latched, and the FSM moves to ISSUE.
- Alignment check:
  - d_req with d_addr[0]=1 goes to ERR instead of ISSUE.
  - ERR lasts one cycle with d_done=1, d_err=1 and no mem_en, then returns to IDLE.
  - The fetch port is never checked; bit 0 of i_addr is forced to 0.
- ISSUE:
  - mem_en=1 and mem_wr = latched wr; mem_addr and mem_wdata are driven from the latch.
  - Counter loads LATENCY-1, then WAIT.
  - When LATENCY=1, go straight to the capture step below.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle mem_rdata is valid (ISSUE cycle + LATENCY), capture it and go to DONE.
- DONE:
  - Exactly one cycle; the winner's done pulse is high with its rdata.
  - Always returns to IDLE. Requests still held in this cycle are not sampled, so there is no double grant.
- Latency: request sampled at the end of cycle 0 → mem_en in cycle 1 → done in cycle LATENCY+2.
- Throughput: one access per LATENCY+3 cycles.
- i_cancel:
  - While the winner is fetch and the state is ISSUE or WAIT, the cancel is recorded.
  - The access runs to completion on the memory, but i_done is suppressed in DONE.
  - i_cancel in IDLE blocks that cycle's fetch grant.
- halt:
  - Has no effect on an in-flight access or on data requests.
  - Blocks new fetch grants only.
- The losing request stays pending. Grants only ever happen from IDLE, so at most one access is outstanding.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding: IDLE=0, ISSUE=1, WAIT=2, DONE=3, ERR=4;
  - winner encoding: WIN_I=0, WIN_D=1;
  - default LATENCY.
- One natural sub-module, mem_arb_lat_cnt: a loadable down-counter with a zero flag, shared with future cache-fill sequencing.
- The FSM and the request latch stay in mem_arbiter.

Test Plan:
1. LATENCY=2, i_req=1, i_addr=0x0010, memory[0x0010]=0x1234 at cycle 0 → mem_en=1 and mem_addr=0x0010 in cycle 1; i_done=1 and i_rdata=0x1234 in cycle 4 only.
2. i_req (0x0002) and d_req read (0x0040) both raised in cycle 0 → data is served first: mem_en in cycle 1, d_done in cycle 4. Fetch gets mem_en in cycle 6 and i_done in cycle 9.
3. Data write d_addr=0x0020, d_wdata=0xBEEF → mem_en=1, mem_wr=1, mem_wdata=0xBEEF in cycle 1; d_done in cycle 4 with d_rdata=0. A following read of 0x0020 returns 0xBEEF.
4. d_req with d_addr=0x0021 in cycle 0 → d_done=1 and d_err=1 in cycle 1, with mem_en never asserted.
5. Fetch granted in cycle 0, i_cancel=1 in cycle 2 → no i_done in cycle 4, FSM in IDLE by cycle 5. A new fetch request is then serviced normally.
6. halt=1 with i_req held → no grant for 10 cycles; a d_req raised meanwhile completes in 4 cycles. rst=0 asserted during WAIT → every output is 0 in the next cycle and no done pulse follows.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, winner tags,
// and latency defaults.
package mem_arb_pkg;

    localparam int LATENCY_DEF = 2;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    typedef enum logic {
        WIN_I = 1'b0,
        WIN_D = 1'b1
    } winner_t;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter with a zero flag; counts memory latency cycles and is
// meant to be reused for cache-fill sequencing.
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data-port accesses onto one fixed-latency memory, one
// access outstanding at a time, with a one-cycle done pulse per access.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_cancel,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    input  logic          halt,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output state_t        dbgState
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_t        state, nextState;
    winner_t       winner;
    logic          wrQ;
    logic          cancelQ;
    logic [AW-1:0] addrQ;
    logic [DW-1:0] wdataQ;
    logic          grantI, grantD;
    logic          cntLoad, cntDec, cntZero;
    logic [CNT_W-1:0] cntVal;
    logic          doneFire;
    logic          fetchKill;

    mem_arb_lat_cnt #(.W(CNT_W)) u_latCnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cntLoad),
        .loadVal (LOAD_VAL),
        .dec     (cntDec),
        .count   (cntVal),
        .zero    (cntZero)
    );

    // Data wins over fetch: it belongs to the older instruction in the pipe.
    always_comb begin
        nextState = state;
        grantI    = 1'b0;
        grantD    = 1'b0;
        cntLoad   = 1'b0;
        cntDec    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req) begin
                    grantD    = 1'b1;
                    nextState = d_addr[0] ? ERR : ISSUE;
                end else if (i_req && !halt && !i_cancel) begin
                    grantI    = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                cntLoad   = 1'b1;
                nextState = WAIT;
            end
            WAIT: begin
                if (cntZero) nextState = DONE;
                else         cntDec    = 1'b1;
            end
            DONE:    nextState = IDLE;
            ERR:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign doneFire  = (state == WAIT) && cntZero;
    // A cancel arriving in the capture cycle itself must also suppress i_done.
    assign fetchKill = cancelQ || i_cancel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            winner    <= WIN_I;
            wrQ       <= 1'b0;
            cancelQ   <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            i_done    <= 1'b0;
            i_rdata   <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            state <= nextState;
            if (grantD) begin
                winner  <= WIN_D;
                wrQ     <= d_wr;
                addrQ   <= d_addr;
                wdataQ  <= d_wdata;
                cancelQ <= 1'b0;
            end else if (grantI) begin
                winner  <= WIN_I;
                wrQ     <= 1'b0;
                addrQ   <= i_addr & ~AW'(1);
                wdataQ  <= '0;
                cancelQ <= 1'b0;
            end else if (winner == WIN_I && (state == ISSUE || state == WAIT) && i_cancel) begin
                cancelQ <= 1'b1;
            end
            mem_en  <= (nextState == ISSUE);
            mem_wr  <= (nextState == ISSUE) && grantD && d_wr;
            i_done  <= doneFire && (winner == WIN_I) && !fetchKill;
            i_rdata <= (doneFire && (winner == WIN_I) && !fetchKill) ? mem_rdata : '0;
            d_done  <= (doneFire && (winner == WIN_D)) || (nextState == ERR);
            d_rdata <= (doneFire && (winner == WIN_D) && !wrQ) ? mem_rdata : '0;
            d_err   <= (nextState == ERR);
        end
    end

    assign mem_addr  = addrQ;
    assign mem_wdata = wdataQ;
    assign dbgState  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a two-cycle-latency memory model and
// hand-computed expected cycles and data.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_cancel;
    logic        i_done;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        d_err;
    logic        halt;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    state_t      dbgState;

    int totalCnt = 0;
    int badCnt   = 0;

    logic [15:0] memArr [0:255];
    logic [15:0] pipe1, pipe2;

    mem_arbiter #(.LATENCY(2), .AW(16), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_cancel  (i_cancel),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .halt      (halt),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbgState  (dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // two-stage memory: data read in the mem_en cycle appears two cycles later
    always @(posedge clk) begin
        if (mem_en && mem_wr) memArr[mem_addr[7:0]] <= mem_wdata;
        pipe1 <= memArr[mem_addr[7:0]];
        pipe2 <= pipe1;
    end
    assign mem_rdata = pipe2;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] allOuts();
        return {11'd0, i_done, i_rdata, d_done, d_rdata, d_err, mem_en, mem_wr, mem_addr, mem_wdata};
    endfunction

    initial begin
        for (int k = 0; k < 256; k++) memArr[k] = 16'h0;
        memArr[8'h10] = 16'h1234;
        memArr[8'h40] = 16'hA5A5;
        memArr[8'h02] = 16'h0F0F;
        memArr[8'h30] = 16'h7777;
        pipe1 = 16'h0;
        pipe2 = 16'h0;

        rst = 1'b0; i_req = 1'b0; i_addr = '0; i_cancel = 1'b0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; halt = 1'b0;
        repeat (3) tick();
        chk("reset_outs", allOuts(), 80'h0);
        chk("reset_state", 80'(dbgState), 80'(IDLE));
        rst = 1'b1;
        tick();

        // single fetch
        i_req = 1'b1; i_addr = 16'h0010;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("t1_mem_en_c%0d", c), 80'(mem_en), 80'(c == 1));
            chk($sformatf("t1_i_done_c%0d", c), 80'(i_done), 80'(c == 4));
            if (c == 1) chk("t1_mem_addr", 80'(mem_addr), 80'h0010);
            if (c == 4) begin
                chk("t1_i_rdata", 80'(i_rdata), 80'h1234);
                i_req = 1'b0;
            end
        end

        // simultaneous requests: data first
        i_req = 1'b1; i_addr = 16'h0002;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("t2_mem_en_c%0d", c), 80'(mem_en), 80'((c == 1) || (c == 6)));
            chk($sformatf("t2_d_done_c%0d", c), 80'(d_done), 80'(c == 4));
            chk($sformatf("t2_i_done_c%0d", c), 80'(i_done), 80'(c == 9));
            if (c == 1) chk("t2_addr_d", 80'(mem_addr), 80'h0040);
            if (c == 4) begin
                chk("t2_d_rdata", 80'(d_rdata), 80'hA5A5);
                d_req = 1'b0;
            end
            if (c == 6) chk("t2_addr_i", 80'(mem_addr), 80'h0002);
            if (c == 9) begin
                chk("t2_i_rdata", 80'(i_rdata), 80'h0F0F);
                i_req = 1'b0;
            end
        end

        // write then read back
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("t3w_d_done_c%0d", c), 80'(d_done), 80'(c == 4));
            if (c == 1) begin
                chk("t3w_mem_en", 80'(mem_en), 80'h1);
                chk("t3w_mem_wr", 80'(mem_wr), 80'h1);
                chk("t3w_mem_wdata", 80'(mem_wdata), 80'hBEEF);
                chk("t3w_mem_addr", 80'(mem_addr), 80'h0020);
            end
            if (c == 4) chk("t3w_d_rdata", 80'(d_rdata), 80'h0);
        end
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_wr = 1'b0; d_wdata = 16'h0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) chk("t3r_mem_wr", 80'(mem_wr), 80'h0);
            chk($sformatf("t3r_d_done_c%0d", c), 80'(d_done), 80'(c == 4));
            if (c == 4) chk("t3r_d_rdata", 80'(d_rdata), 80'hBEEF);
        end
        d_req = 1'b0;
        tick();

        // unaligned data access
        d_req = 1'b1; d_addr = 16'h0021;
        tick();
        chk("t4_d_done", 80'(d_done), 80'h1);
        chk("t4_d_err", 80'(d_err), 80'h1);
        chk("t4_mem_en_c1", 80'(mem_en), 80'h0);
        chk("t4_state_c1", 80'(dbgState), 80'(ERR));
        d_req = 1'b0;
        tick();
        chk("t4_d_done_c2", 80'(d_done), 80'h0);
        chk("t4_d_err_c2", 80'(d_err), 80'h0);
        chk("t4_mem_en_c2", 80'(mem_en), 80'h0);
        chk("t4_state_c2", 80'(dbgState), 80'(IDLE));
        tick();
        chk("t4_mem_en_c3", 80'(mem_en), 80'h0);

        // cancelled fetch, then an odd fetch address served from the even word
        i_req = 1'b1; i_addr = 16'h0030;
        tick();
        chk("t5_mem_en", 80'(mem_en), 80'h1);
        tick();
        i_req = 1'b0; i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        chk("t5_i_done_c3", 80'(i_done), 80'h0);
        tick();
        chk("t5_i_done_c4", 80'(i_done), 80'h0);
        tick();
        chk("t5_i_done_c5", 80'(i_done), 80'h0);
        chk("t5_state_c5", 80'(dbgState), 80'(IDLE));
        i_req = 1'b1; i_addr = 16'h0011;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) chk("t5_addr_even", 80'(mem_addr), 80'h0010);
            chk($sformatf("t5n_i_done_c%0d", c), 80'(i_done), 80'(c == 4));
            if (c == 4) chk("t5n_i_rdata", 80'(i_rdata), 80'h1234);
        end
        i_req = 1'b0;
        tick();

        // halt blocks fetch grants only
        halt = 1'b1; i_req = 1'b1; i_addr = 16'h0010;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("t6_halt_a_c%0d", c), 80'(mem_en), 80'h0);
        end
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("t6_d_mem_en_c%0d", c), 80'(mem_en), 80'(c == 1));
            chk($sformatf("t6_d_done_c%0d", c), 80'(d_done), 80'(c == 4));
            if (c == 4) chk("t6_d_rdata", 80'(d_rdata), 80'hA5A5);
        end
        d_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("t6_halt_b_c%0d", c), 80'(mem_en | i_done), 80'h0);
        end

        // reset in the middle of an access
        halt = 1'b0;
        tick();
        chk("t6_fetch_issue", 80'(mem_en), 80'h1);
        tick();
        chk("t6_state_wait", 80'(dbgState), 80'(WAIT));
        rst = 1'b0;
        tick();
        chk("t6_rst_outs", allOuts(), 80'h0);
        chk("t6_rst_state", 80'(dbgState), 80'(IDLE));
        rst = 1'b1; i_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("t6_post_rst_c%0d", c), 80'({i_done, d_done, mem_en}), 80'h0);
        end

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
